// File: rtl/interrupt_timer_ctrl_pkg.sv
// Shared constants and types for the memory-mapped timer / interrupt controller.
package interrupt_timer_ctrl_pkg;

  // Byte offsets from the register window base
  localparam logic [4:0] OFF_TH    = 5'h00;
  localparam logic [4:0] OFF_TL    = 5'h04;
  localparam logic [4:0] OFF_TCON  = 5'h08;
  localparam logic [4:0] OFF_CAUSE = 5'h0C;
  localparam logic [4:0] OFF_PSC   = 5'h10;

  localparam int TCON_RUN    = 0;
  localparam int TCON_INT_EN = 1;
  localparam int TCON_STATUS = 2;

  localparam int CAUSE_TIMER = 0;
  localparam int CAUSE_EXT   = 1;

  typedef enum logic [1:0] {IDLE, PEND, SERV} irq_state_e;

endpackage

// File: rtl/interrupt_timer_ctrl_core.sv
// Timer register file: TH/TL/TCON storage, reload on overflow, optional prescaler.
// Prescaler and PSC register exist only when TIMER_PRESCALE_EN is defined.
module irq_timer_core
  import interrupt_timer_ctrl_pkg::*;
#(
  parameter int PSC_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  off,
  input  logic [31:0] wdata,
  output logic        status,
  output logic        int_en,
  output logic [31:0] rd_data
);

  logic [31:0] th, tl;
  logic        run;
  logic        tick, wrap;

`ifdef TIMER_PRESCALE_EN
  logic [PSC_WIDTH-1:0] psc, psc_cnt;

  assign tick = run && (psc_cnt == psc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc     <= '0;
      psc_cnt <= '0;
    end else if (we && off == OFF_PSC) begin
      psc     <= wdata[PSC_WIDTH-1:0];
      psc_cnt <= '0;
    end else if (run) begin
      psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
    end
  end
`else
  assign tick = run;
`endif

  assign wrap = tick && (tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th     <= '0;
      tl     <= '0;
      run    <= 1'b0;
      int_en <= 1'b0;
      status <= 1'b0;
    end else begin
      if (we && off == OFF_TH) th <= wdata;
      // Software TL write beats the hardware count/reload
      if (we && off == OFF_TL) tl <= wdata;
      else if (tick)           tl <= wrap ? th : tl + 32'd1;
      // A wrap landing on a status-clearing write still sets status
      if (we && off == OFF_TCON) begin
        run    <= wdata[TCON_RUN];
        int_en <= wdata[TCON_INT_EN];
        status <= wdata[TCON_STATUS] | (wrap && int_en);
      end else if (wrap && int_en) begin
        status <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_TH:   rd_data = th;
      OFF_TL:   rd_data = tl;
      OFF_TCON: rd_data = {29'b0, status, int_en, run};
`ifdef TIMER_PRESCALE_EN
      OFF_PSC:  rd_data = 32'(psc);
`endif
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: rtl/interrupt_timer_ctrl.sv
// MEM-stage timer/interrupt controller: bus decode, interrupt sequencing FSM, cause latch.
// Optional TIMER_PRESCALE_EN adds the PSC register at BASE_ADDR+0x10.
module interrupt_timer_ctrl
  import interrupt_timer_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PSC_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        sel,
  output logic [31:0] rdata,
  input  logic        ext_irq,
  input  logic        kernel_mode,
  input  logic        irq_ack,
  input  logic        eret,
  output logic        irq_req,
  output logic [1:0]  irq_cause
);

  irq_state_e  state;
  logic [4:0]  off;
  logic [31:0] core_rd;
  logic        status, int_en, timer_src;

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] PSC_ADDR = BASE_ADDR + 32'(OFF_PSC);
  assign sel = (addr[31:4] == BASE_ADDR[31:4]) || (addr[31:2] == PSC_ADDR[31:2]);
`else
  assign sel = (addr[31:4] == BASE_ADDR[31:4]);
`endif

  assign off = addr[4:0] - BASE_ADDR[4:0];

  irq_timer_core #(.PSC_WIDTH(PSC_WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .we      (mem_write && sel),
    .off     (off),
    .wdata   (wdata),
    .status  (status),
    .int_en  (int_en),
    .rd_data (core_rd)
  );

  always_comb begin
    rdata = '0;
    if (sel && mem_read)
      rdata = (off == OFF_CAUSE) ? {30'b0, irq_cause} : core_rd;
  end

  assign timer_src = status && int_en;

  // Once raised, irq_req holds until the pipeline acks; SERV masks all sources until eret
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      irq_req   <= 1'b0;
      irq_cause <= '0;
    end else begin
      case (state)
        IDLE: if ((timer_src || ext_irq) && !kernel_mode) begin
          irq_cause[CAUSE_TIMER] <= timer_src;
          irq_cause[CAUSE_EXT]   <= ext_irq;
          irq_req                <= 1'b1;
          state                  <= PEND;
        end
        PEND: if (irq_ack) begin
          irq_req <= 1'b0;
          state   <= SERV;
        end
        SERV: if (eret) state <= IDLE;
        default: begin
          irq_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
